// File: rtl/joy_pkg.sv
// Shared types and constants for the serial joystick chain reader.
package joy_pkg;

    localparam int JOY_WORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LATCH,
        ST_SHIFT,
        ST_COMMIT,
        ST_GAP
    } joy_state_t;

    // Ticks in one scan frame (COMMIT adds one extra clk on top of this).
    function automatic int joy_frame_ticks(input int players, input int bits, input int gap_ticks);
        return 2 + 2 * players * bits + gap_ticks;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-player debounce: holds the last raw word, its run length and the committed word.
module joy_debounce
    import joy_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  commit,
    input  logic [JOY_WORD_W-1:0] word_in,
    output logic [JOY_WORD_W-1:0] word_out
);

    logic [JOY_WORD_W-1:0] raw;
    logic [2:0]            cnt;
    logic [2:0]            cnt_nx;

    // Run length of identical frames including this one, saturating at 7.
    always_comb begin
        cnt_nx = 3'd1;
        if (word_in == raw)
            cnt_nx = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
    end

    // Record the frame and commit once the word has been stable long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw      <= '0;
            cnt      <= '0;
            word_out <= '0;
        end else if (commit) begin
            raw <= word_in;
            cnt <= cnt_nx;
            if (cnt_nx >= 3'(DEBOUNCE))
                word_out <= word_in;
        end
    end

endmodule

// File: rtl/joy_serial_chain.sv
// Scanner for a chain of 74HC165-style pads: load, shift, debounce, publish.
module joy_serial_chain
    import joy_pkg::*;
#(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 12,
    parameter int CLK_DIV    = 12,
    parameter int GAP_TICKS  = 8,
    parameter int DEBOUNCE   = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          joy_data,
    output logic                          joy_clk,
    output logic                          joy_load,
    output logic [PLAYERS*JOY_WORD_W-1:0] joystick,
    output logic                          frame_done
);

    localparam int NBITS = PLAYERS * BITS;
    localparam int KW    = $clog2(NBITS) + 1;
    localparam int TW    = $clog2(CLK_DIV);
    localparam int GW    = $clog2(GAP_TICKS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NBITS - 1);

    logic [1:0]       sync;
    logic             data_s;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    joy_state_t       state, state_nx;
    logic             phase, phase_nx;     // 0: joy_clk low half, 1: high half
    logic [KW-1:0]    k, k_nx;
    logic [GW-1:0]    gap_cnt, gap_nx;
    logic             joy_clk_nx, joy_load_nx, sample, commit;
    logic [NBITS-1:0] sbuf;                // bit k = player k/BITS, bit k%BITS

    assign data_s = sync[1];
    assign tick   = enable && (tick_cnt == TW'(CLK_DIV - 1));

    // Two-flop synchroniser for the asynchronous chain output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], joy_data};
    end

    // Tick divider; cleared while disabled and frozen during the one-clk COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                tick_cnt <= '0;
        else if (!enable)            tick_cnt <= '0;
        else if (state == ST_COMMIT) tick_cnt <= tick_cnt;
        else if (tick)               tick_cnt <= '0;
        else                         tick_cnt <= tick_cnt + 1'b1;
    end

    // FSM state register with its bit index, shift phase and gap counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            phase   <= 1'b0;
            k       <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            k       <= k_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Next state: dropping enable abandons the frame at once.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        k_nx     = k;
        gap_nx   = gap_cnt;
        if (!enable) begin
            state_nx = ST_IDLE;
            phase_nx = 1'b0;
            k_nx     = '0;
            gap_nx   = '0;
        end else if (state == ST_COMMIT) begin
            state_nx = ST_GAP;
        end else if (tick) begin
            case (state)
                ST_IDLE:  state_nx = ST_LOAD;
                ST_LOAD:  state_nx = ST_LATCH;
                ST_LATCH: begin
                    state_nx = ST_SHIFT;
                    k_nx     = '0;
                    phase_nx = 1'b0;
                end
                ST_SHIFT: begin
                    if (!phase) begin
                        phase_nx = 1'b1;
                    end else begin
                        phase_nx = 1'b0;
                        if (k == K_LAST) state_nx = ST_COMMIT;
                        else             k_nx = k + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                        state_nx = ST_LOAD;
                        gap_nx   = '0;
                    end else begin
                        gap_nx = gap_cnt + 1'b1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs derived from the upcoming state so the pins are registered.
    always_comb begin
        joy_load_nx = (state_nx != ST_LOAD);
        joy_clk_nx  = !(state_nx == ST_SHIFT && !phase_nx);
        sample      = tick && state == ST_SHIFT && !phase;
        commit      = enable && state == ST_COMMIT;
    end

    // Pin registers, frame strobe and shift buffer capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy_clk    <= 1'b1;
            joy_load   <= 1'b1;
            frame_done <= 1'b0;
            sbuf       <= '0;
        end else begin
            joy_clk    <= joy_clk_nx;
            joy_load   <= joy_load_nx;
            frame_done <= commit;
            if (sample)
                for (int i = 0; i < NBITS; i++)
                    if (k == KW'(i)) sbuf[i] <= data_s;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [JOY_WORD_W-1:0] word;

        // Slice this player's bits out of the frame, normalise polarity, zero-extend.
        always_comb begin
            word = '0;
            for (int b = 0; b < BITS; b++)
                word[b] = sbuf[p*BITS + b] ^ ACTIVE_LOW;
        end

        joy_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .commit   (commit),
            .word_in  (word),
            .word_out (joystick[p*JOY_WORD_W +: JOY_WORD_W])
        );
    end

endmodule

// File: tb/tb_joy_serial_chain.sv
// Bench for joy_serial_chain: three configurations, each fed by a '165 chain model.
module tb_joy_serial_chain;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic data0, data1, data2;
    logic jclk0, jclk1, jclk2, jload0, jload1, jload2, fd0, fd1, fd2;
    logic [31:0] joy0, joy1;
    logic [63:0] joy2;
    int checks = 0;
    int errors = 0;

    logic [11:0] lastr0, lastr1;

    always #5 clk = ~clk;

    // u0: defaults; u1: DEBOUNCE=1; u2: 4 pads x 8 bits, active high, fast divider.
    joy_serial_chain u0 (.clk(clk), .reset_n(reset_n), .enable(en0), .joy_data(data0),
        .joy_clk(jclk0), .joy_load(jload0), .joystick(joy0), .frame_done(fd0));
    joy_serial_chain #(.DEBOUNCE(1)) u1 (.clk(clk), .reset_n(reset_n), .enable(en1),
        .joy_data(data1), .joy_clk(jclk1), .joy_load(jload1), .joystick(joy1), .frame_done(fd1));
    joy_serial_chain #(.PLAYERS(4), .BITS(8), .CLK_DIV(4), .GAP_TICKS(2), .ACTIVE_LOW(1'b0)) u2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .joy_data(data2), .joy_clk(jclk2),
        .joy_load(jload2), .joystick(joy2), .frame_done(fd2));

    // Chain models: str holds pad inputs in shift-out order (first pad's bit 0 first).
    logic [23:0] str0 = '1, preg0 = '1;
    logic [23:0] str1 = '1, preg1 = '1;
    logic [31:0] str2 = '0, preg2 = '0;
    int idx0 = 0, idx1 = 0, idx2 = 0;
    always @(negedge jload0) begin preg0 = str0; idx0 = 0; end
    always @(negedge jload1) begin preg1 = str1; idx1 = 0; end
    always @(negedge jload2) begin preg2 = str2; idx2 = 0; end
    always @(posedge jclk0) if (jload0 === 1'b1) idx0++;
    always @(posedge jclk1) if (jload1 === 1'b1) idx1++;
    always @(posedge jclk2) if (jload2 === 1'b1) idx2++;
    assign data0 = (idx0 < 24) ? preg0[idx0] : 1'b1;
    assign data1 = (idx1 < 24) ? preg1[idx1] : 1'b1;
    assign data2 = (idx2 < 32) ? preg2[idx2] : 1'b0;

    // Clk count (posedges) until the chosen unit's frame_done is seen; -1 on timeout.
    task automatic wait_fd(input int which, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0 && fd0) || (which == 1 && fd1) || (which == 2 && fd2)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks += 6;
        if (joy0 !== 32'h0) begin errors++; $display("FAIL reset_joy0: got %h want 0", joy0); end
        if (joy2 !== 64'h0) begin errors++; $display("FAIL reset_joy2: got %h want 0", joy2); end
        if (jclk0 !== 1'b1) begin errors++; $display("FAIL reset_jclk: got %b want 1", jclk0); end
        if (jload0 !== 1'b1) begin errors++; $display("FAIL reset_jload: got %b want 1", jload0); end
        if (fd0 !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b want 0", fd0); end
        if (jload2 !== 1'b1) begin errors++; $display("FAIL reset_jload2: got %b want 1", jload2); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Pad 1 bit0 pressed, pad 2 bit11 pressed; needs two identical frames.
    task automatic test_pads;
        int c;
        str0 = {12'h7FF, 12'hFFE};
        @(negedge clk);
        en0 = 1'b1;
        wait_fd(0, 2000, c);
        checks += 3;
        // IDLE waits one tick, then LOAD+LATCH+48 shift ticks, then COMMIT.
        if (c !== 12 * 51 + 1) begin errors++; $display("FAIL first_frame_latency: got %0d want %0d", c, 12*51+1); end
        if (joy0 !== 32'h0) begin errors++; $display("FAIL pads_frame1: got %h want 0", joy0); end
        wait_fd(0, 2000, c);
        if (joy0 !== 32'h0800_0001) begin errors++; $display("FAIL pads_frame2: got %h want 08000001", joy0); end
        lastr0 = 12'hFFE; lastr1 = 12'h7FF;
    endtask

    task automatic test_frame_timing;
        int cyc, load_low, pulses, bad_len, run;
        logic prev;
        cyc = 0; load_low = 0; pulses = 0; bad_len = 0; run = 0; prev = jclk0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (!jload0) load_low++;
            if (prev && !jclk0) pulses++;
            if (!jclk0) run++;
            if (!prev && jclk0) begin
                if (run != 12) bad_len++;
                run = 0;
            end
            prev = jclk0;
            if (fd0) begin cyc = i; break; end
        end
        checks += 4;
        if (cyc !== 697) begin errors++; $display("FAIL frame_period: got %0d want 697", cyc); end
        if (load_low !== 12) begin errors++; $display("FAIL load_low_len: got %0d want 12", load_low); end
        if (pulses !== 24) begin errors++; $display("FAIL clk_pulses: got %0d want 24", pulses); end
        if (bad_len !== 0) begin errors++; $display("FAIL clk_pulse_len: got %0d bad want 0", bad_len); end
    endtask

    // One-frame press of pad 1 bit4: hidden at DEBOUNCE=2, visible one frame at 1.
    task automatic test_glitch;
        int c;
        logic seen;
        seen = 1'b0;
        str0 = {12'h7FF, 12'hFEE};
        wait_fd(0, 1000, c); if (joy0[4]) seen = 1'b1;
        str0 = {12'h7FF, 12'hFFE};
        wait_fd(0, 1000, c); if (joy0[4]) seen = 1'b1;
        wait_fd(0, 1000, c); if (joy0[4]) seen = 1'b1;
        checks += 2;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch_d2: got bit4 seen=%b want 0", seen); end
        if (c < 0) begin errors++; $display("FAIL glitch_d2_timeout: got %0d want >0", c); end

        str1 = {12'h7FF, 12'hFFE};
        @(negedge clk);
        en1 = 1'b1;
        wait_fd(1, 2000, c);
        checks += 3;
        if (joy1 !== 32'h0800_0001) begin errors++; $display("FAIL glitch_d1_base: got %h want 08000001", joy1); end
        str1 = {12'h7FF, 12'hFEE};
        wait_fd(1, 1000, c);
        if (joy1 !== 32'h0800_0011) begin errors++; $display("FAIL glitch_d1_press: got %h want 08000011", joy1); end
        str1 = {12'h7FF, 12'hFFE};
        wait_fd(1, 1000, c);
        if (joy1 !== 32'h0800_0001) begin errors++; $display("FAIL glitch_d1_release: got %h want 08000001", joy1); end
    endtask

    // Random pads against a model: output follows the latest word whose
    // trailing run of identical frames has reached DEBOUNCE (2).
    task automatic test_random;
        logic [15:0] h0[$], h1[$];
        logic [15:0] e0, e1, w;
        logic [11:0] pool[3];
        int c, run;
        for (int i = 0; i < 3; i++) pool[i] = 12'($urandom);
        pool[0] = 12'hFFF;
        h0.push_back(16'h0001); h0.push_back(16'h0001);
        h1.push_back(16'h0800); h1.push_back(16'h0800);
        e0 = 16'h0001; e1 = 16'h0800;
        for (int f = 0; f < 10; f++) begin
            lastr0 = pool[$urandom_range(0, 2)];
            lastr1 = pool[$urandom_range(0, 2)];
            str0 = {lastr1, lastr0};
            wait_fd(0, 1000, c);
            w = {4'h0, ~lastr0};
            h0.push_back(w);
            run = 0;
            for (int i = h0.size() - 1; i >= 0 && h0[i] == w; i--) run++;
            if (run >= 2) e0 = w;
            w = {4'h0, ~lastr1};
            h1.push_back(w);
            run = 0;
            for (int i = h1.size() - 1; i >= 0 && h1[i] == w; i--) run++;
            if (run >= 2) e1 = w;
            checks++;
            if (joy0 !== {e1, e0}) begin errors++; $display("FAIL random_frame%0d: got %h want %h", f, joy0, {e1, e0}); end
        end
    endtask

    task automatic test_wide;
        int c;
        logic [7:0] r0, r1, r2;
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        str2 = {8'hA5, r2, r1, r0};
        @(negedge clk);
        en2 = 1'b1;
        wait_fd(2, 1000, c);
        checks += 4;
        if (joy2 !== 64'h0) begin errors++; $display("FAIL wide_frame1: got %h want 0", joy2); end
        wait_fd(2, 1000, c);
        if (c !== 4 * (2 + 64 + 2) + 1) begin errors++; $display("FAIL wide_period: got %0d want 273", c); end
        if (joy2[63:48] !== 16'h00A5) begin errors++; $display("FAIL wide_pad3: got %h want 00a5", joy2[63:48]); end
        if (joy2 !== {16'h00A5, 8'h0, r2, 8'h0, r1, 8'h0, r0}) begin
            errors++; $display("FAIL wide_all: got %h want %h", joy2, {16'h00A5, 8'h0, r2, 8'h0, r1, 8'h0, r0});
        end
    endtask

    // Drop enable during bit 10's low phase: the frame must vanish without trace.
    task automatic test_enable_drop;
        int c, n, fdn, evt, at;
        logic prev, changed;
        logic [31:0] snap;
        logic [11:0] x0, x1;
        wait_fd(0, 1000, c);
        x0 = ~lastr0; x1 = ~lastr1;
        str0 = {x1, x0};
        n = 0; prev = jclk0;
        for (int i = 0; i < 1000 && n < 11; i++) begin
            @(negedge clk);
            if (prev && !jclk0) n++;
            prev = jclk0;
        end
        en0 = 1'b0;
        snap = joy0;
        repeat (12) @(negedge clk);
        checks += 5;
        if (n !== 11) begin errors++; $display("FAIL drop_find_k10: got %0d want 11", n); end
        if ({jclk0, jload0} !== 2'b11) begin errors++; $display("FAIL drop_idle_pins: got %b want 11", {jclk0, jload0}); end
        fdn = 0; changed = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (fd0) fdn++;
            if (joy0 !== snap) changed = 1'b1;
        end
        if (fdn !== 0) begin errors++; $display("FAIL drop_no_fd: got %0d want 0", fdn); end
        if (changed !== 1'b0) begin errors++; $display("FAIL drop_hold: got changed=%b want 0", changed); end
        en0 = 1'b1;
        evt = 0; at = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!jload0) begin evt = 1; at = i; break; end
            if (!jclk0)  begin evt = 2; at = i; break; end
        end
        if (evt !== 1 || at !== 12) begin errors++; $display("FAIL reenable_load_first: got evt=%0d at=%0d want evt=1 at=12", evt, at); end
        wait_fd(0, 1000, c);
        checks += 3;
        if (c !== 601) begin errors++; $display("FAIL reenable_latency: got %0d want 601", c); end
        // Only one complete frame of the new word so far: nothing commits yet.
        if (joy0 !== snap) begin errors++; $display("FAIL reenable_frame1: got %h want %h", joy0, snap); end
        wait_fd(0, 1000, c);
        if (joy0 !== {4'h0, ~x1, 4'h0, ~x0}) begin
            errors++; $display("FAIL reenable_frame2: got %h want %h", joy0, {4'h0, ~x1, 4'h0, ~x0});
        end
    endtask

    task automatic test_reset_midgap;
        int c;
        wait_fd(0, 1000, c);
        repeat (30) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (joy0 !== 32'h0) begin errors++; $display("FAIL async_reset_joy0: got %h want 0", joy0); end
        if (joy1 !== 32'h0) begin errors++; $display("FAIL async_reset_joy1: got %h want 0", joy1); end
        if ({jclk0, jload0, fd0} !== 3'b110) begin errors++; $display("FAIL async_reset_pins: got %b want 110", {jclk0, jload0, fd0}); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_fd(0, 2000, c);
        if (c !== 613) begin errors++; $display("FAIL restart_first_fd: got %0d want 613", c); end
        wait_fd(0, 1000, c);
        if (c !== 697) begin errors++; $display("FAIL restart_period: got %0d want 697", c); end
    endtask

    initial begin
        test_reset;
        test_pads;
        test_frame_timing;
        test_glitch;
        test_random;
        test_wide;
        test_enable_drop;
        test_reset_midgap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
